// File: rtl/phy_tx_pkg.sv
// Shared definitions for the phy_tx lane scheduling path: idle symbol, grant state encoding, widths.
package phy_tx_pkg;

    localparam int unsigned DEF_DATA_W = 8;
    localparam logic [7:0]  IDLE_SYM   = 8'hBC;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2
    } gnt_state_e;

    // Width of an occupancy counter that must represent 0..depth inclusive.
    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/lane_fifo.sv
// Per-lane symbol FIFO: power-of-two depth, wrapping pointers, occupancy count, full/empty flags.
module lane_fifo
    import phy_tx_pkg::*;
#(
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                           clk_2f,
    input  logic                           reset,
    input  logic                           push,
    input  logic [DATA_W-1:0]              din,
    input  logic                           pop,
    output logic [DATA_W-1:0]              dout,
    output logic                           full,
    output logic                           empty,
    output logic [cnt_w(FIFO_DEPTH)-1:0]   count
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = cnt_w(FIFO_DEPTH);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    // Full is judged on the pre-edge count, so a same-cycle pop never admits a write to a full FIFO.
    assign full    = (count == CNT_W'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk_2f) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk_2f or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/lane_rr_scheduler.sv
// Two-lane round-robin scheduler onto one symbol lane toward the serializer; emits IDLE_SYM when nothing is pending.
// Define LANE_STRICT_PRIO_EN to make lane 0 win whenever it has data (round-robin otherwise).
module lane_rr_scheduler
    import phy_tx_pkg::*;
#(
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk_2f,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in_0,
    input  logic              valid_in_0,
    output logic              ready_in_0,
    input  logic [DATA_W-1:0] data_in_1,
    input  logic              valid_in_1,
    output logic              ready_in_1,
    input  logic              ready_out,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic              lane_sel,
    output logic              ovf_0,
    output logic              ovf_1
);

    localparam int unsigned CNT_W = cnt_w(FIFO_DEPTH);

    gnt_state_e        state;
    gnt_state_e        state_nxt;
    logic              advance;
    logic              pop_0;
    logic              pop_1;
    logic [DATA_W-1:0] head_0;
    logic [DATA_W-1:0] head_1;
    logic              full_0;
    logic              full_1;
    logic              empty_0;
    logic              empty_1;
    logic [CNT_W-1:0]  count_0;
    logic [CNT_W-1:0]  count_1;
`ifndef LANE_STRICT_PRIO_EN
    logic              last;
`endif

    lane_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo_0 (
        .clk_2f (clk_2f),
        .reset  (reset),
        .push   (valid_in_0),
        .din    (data_in_0),
        .pop    (pop_0),
        .dout   (head_0),
        .full   (full_0),
        .empty  (empty_0),
        .count  (count_0)
    );

    lane_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo_1 (
        .clk_2f (clk_2f),
        .reset  (reset),
        .push   (valid_in_1),
        .din    (data_in_1),
        .pop    (pop_1),
        .dout   (head_1),
        .full   (full_1),
        .empty  (empty_1),
        .count  (count_1)
    );

    // Ready is held low while reset is asserted so sources never see a phantom accept.
    assign ready_in_0 = reset && (count_0 < CNT_W'(FIFO_DEPTH));
    assign ready_in_1 = reset && (count_1 < CNT_W'(FIFO_DEPTH));
    assign advance    = ready_out || !valid_out;

    // Grant selection for the next output register load.
    always_comb begin
        state_nxt = state;
        pop_0     = 1'b0;
        pop_1     = 1'b0;
        if (advance) begin
`ifdef LANE_STRICT_PRIO_EN
            if (!empty_0) begin
                state_nxt = ST_GNT0;
            end else if (!empty_1) begin
                state_nxt = ST_GNT1;
            end else begin
                state_nxt = ST_IDLE;
            end
`else
            if (!empty_0 && !empty_1) begin
                state_nxt = last ? ST_GNT0 : ST_GNT1;
            end else if (!empty_0) begin
                state_nxt = ST_GNT0;
            end else if (!empty_1) begin
                state_nxt = ST_GNT1;
            end else begin
                state_nxt = ST_IDLE;
            end
`endif
            pop_0 = (state_nxt == ST_GNT0);
            pop_1 = (state_nxt == ST_GNT1);
        end
    end

    always_ff @(posedge clk_2f or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            data_out  <= DATA_W'(IDLE_SYM);
            valid_out <= 1'b0;
            lane_sel  <= 1'b0;
`ifndef LANE_STRICT_PRIO_EN
            last      <= 1'b1;
`endif
        end else if (advance) begin
            state <= state_nxt;
            case (state_nxt)
                ST_GNT0: begin
                    data_out  <= head_0;
                    valid_out <= 1'b1;
                    lane_sel  <= 1'b0;
`ifndef LANE_STRICT_PRIO_EN
                    last      <= 1'b0;
`endif
                end
                ST_GNT1: begin
                    data_out  <= head_1;
                    valid_out <= 1'b1;
                    lane_sel  <= 1'b1;
`ifndef LANE_STRICT_PRIO_EN
                    last      <= 1'b1;
`endif
                end
                default: begin
                    data_out  <= DATA_W'(IDLE_SYM);
                    valid_out <= 1'b0;
                end
            endcase
        end
    end

    // Sticky overflow flags: a write offered to a full FIFO is lost.
    always_ff @(posedge clk_2f or negedge reset) begin
        if (!reset) begin
            ovf_0 <= 1'b0;
            ovf_1 <= 1'b0;
        end else begin
            if (valid_in_0 && full_0) begin
                ovf_0 <= 1'b1;
            end
            if (valid_in_1 && full_1) begin
                ovf_1 <= 1'b1;
            end
        end
    end

endmodule
